// File: rtl/wb_arbiter_if.sv
// Bus bundle for the writeback arbiter: ALU/memory result inputs, load scoreboard
// queries, and the registered register-file write port.
interface wb_arbiter_if #(
  parameter int WORD_LEN      = 32,
  parameter int REG_IDX_WIDTH = 5,
  parameter int ADDR_SIZE     = 32
);
  logic                     aluValid;
  logic [REG_IDX_WIDTH-1:0] aluAddr;
  logic [WORD_LEN-1:0]      aluData;
  logic [ADDR_SIZE-1:0]     aluPc;
  logic                     memValid;
  logic                     memReady;
  logic [REG_IDX_WIDTH-1:0] memAddr;
  logic [WORD_LEN-1:0]      memData;
  logic [ADDR_SIZE-1:0]     memPc;
  logic                     loadIssue;
  logic [REG_IDX_WIDTH-1:0] loadIssueAddr;
  logic [REG_IDX_WIDTH-1:0] readAddr1;
  logic [REG_IDX_WIDTH-1:0] readAddr2;
  logic                     busy1;
  logic                     busy2;
  logic                     writeEnable;
  logic [REG_IDX_WIDTH-1:0] writeAddr;
  logic [WORD_LEN-1:0]      writeData;
  logic [ADDR_SIZE-1:0]     pc;

  modport slave (
    input  aluValid, aluAddr, aluData, aluPc,
    input  memValid, memAddr, memData, memPc,
    input  loadIssue, loadIssueAddr, readAddr1, readAddr2,
    output memReady, busy1, busy2,
    output writeEnable, writeAddr, writeData, pc
  );

  modport master (
    output aluValid, aluAddr, aluData, aluPc,
    output memValid, memAddr, memData, memPc,
    output loadIssue, loadIssueAddr, readAddr1, readAddr2,
    input  memReady, busy1, busy2,
    input  writeEnable, writeAddr, writeData, pc
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results first, then queued loads, then load bypass; keeps the
// pending-load scoreboard. Optional WB_STATS_EN adds write/stall counters.
module wb_arbiter #(
  parameter int WORD_LEN      = 32,
  parameter int REG_IDX_WIDTH = 5,
  parameter int ADDR_SIZE     = 32,
  parameter int REG_COUNT     = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rstn,
  wb_arbiter_if.slave     bus
`ifdef WB_STATS_EN
  ,
  output logic [31:0]     statWrites,
  output logic [31:0]     statStalls
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [REG_IDX_WIDTH-1:0] addr;
    logic [WORD_LEN-1:0]      data;
    logic [ADDR_SIZE-1:0]     pc;
  } entry_t;

  entry_t                   fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [REG_COUNT-1:0]     busy_q, busy_d;
  logic                     we_q, we_d;
  logic [REG_IDX_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_LEN-1:0]      data_q, data_d;
  logic [ADDR_SIZE-1:0]     pc_q, pc_d;

  logic   fifo_empty, mem_ready, mem_acc, pop, bypass, push;
  entry_t head, mem_in;

  assign fifo_empty = (count_q == '0);
  // Ready depends only on the registered count, never on memValid.
  assign mem_ready  = rstn && (count_q != CNT_W'(FIFO_DEPTH));
  assign mem_acc    = bus.memValid && mem_ready;
  assign pop        = !bus.aluValid && !fifo_empty;
  assign bypass     = !bus.aluValid && fifo_empty && mem_acc;
  assign push       = mem_acc && !bypass;

  assign head   = fifo_q[rd_ptr_q];
  assign mem_in = '{addr: bus.memAddr, data: bus.memData, pc: bus.memPc};

  always_comb begin
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    pc_d     = pc_q;
    busy_d   = busy_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (bus.aluValid) begin
      we_d   = (bus.aluAddr != '0);
      addr_d = bus.aluAddr;
      data_d = bus.aluData;
      pc_d   = bus.aluPc;
    end else if (pop) begin
      we_d             = (head.addr != '0);
      addr_d           = head.addr;
      data_d           = head.data;
      pc_d             = head.pc;
      busy_d[head.addr] = 1'b0;
      rd_ptr_d         = rd_ptr_q + 1'b1;
    end else if (bypass) begin
      we_d                = (mem_in.addr != '0);
      addr_d              = mem_in.addr;
      data_d              = mem_in.data;
      pc_d                = mem_in.pc;
      busy_d[mem_in.addr] = 1'b0;
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A newly issuing load outranks a retiring one on the same register.
    if (bus.loadIssue) busy_d[bus.loadIssueAddr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      pc_q     <= '0;
      busy_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      pc_q     <= pc_d;
      busy_q   <= busy_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem_in;
  end

  assign bus.memReady    = mem_ready;
  assign bus.busy1       = busy_q[bus.readAddr1];
  assign bus.busy2       = busy_q[bus.readAddr2];
  assign bus.writeEnable = we_q;
  assign bus.writeAddr   = addr_q;
  assign bus.writeData   = data_q;
  assign bus.pc          = pc_q;

`ifdef WB_STATS_EN
  logic [31:0] stat_writes_q, stat_stalls_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_writes_q <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (we_q) stat_writes_q <= stat_writes_q + 32'd1;
      if (bus.memValid && !mem_ready) stat_stalls_q <= stat_stalls_q + 32'd1;
    end
  end

  assign statWrites = stat_writes_q;
  assign statStalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then random traffic, all
// checked against a queue-based reference model of the writeback rules.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if bus_if ();
`ifdef WB_STATS_EN
  logic [31:0] statWrites, statStalls;
`endif

  wb_arbiter dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
`ifdef WB_STATS_EN
    ,
    .statWrites (statWrites),
    .statStalls (statStalls)
`endif
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  ent_t        q[$];
  bit          busy[32];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data, m_pc;
  bit          m_acc;
  int unsigned m_writes, m_stalls;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus_if.aluValid = 0; bus_if.aluAddr = 0; bus_if.aluData = 0; bus_if.aluPc = 0;
    bus_if.memValid = 0; bus_if.memAddr = 0; bus_if.memData = 0; bus_if.memPc = 0;
    bus_if.loadIssue = 0; bus_if.loadIssueAddr = 0;
    bus_if.readAddr1 = 0; bus_if.readAddr2 = 0;
  endtask

  task automatic retire(input ent_t e);
    m_we   = (e.a != 0);
    m_addr = e.a; m_data = e.d; m_pc = e.p;
    busy[e.a] = 0;
  endtask

  // One clock: predict from current inputs, then compare registered outputs after the edge.
  task automatic step();
    bit   in_rst, ready, byp;
    ent_t e;
    #1;
    in_rst = !rstn;
    m_acc  = 0;
    if (in_rst) begin
      chk("memReady_in_reset", bus_if.memReady, 0);
      q.delete();
      foreach (busy[i]) busy[i] = 0;
      m_we = 0; m_addr = 0; m_data = 0; m_pc = 0;
      m_writes = 0; m_stalls = 0;
    end else begin
      ready = (q.size() < 4);
      chk("memReady", bus_if.memReady, ready);
      chk("busy1", bus_if.busy1, busy[bus_if.readAddr1]);
      chk("busy2", bus_if.busy2, busy[bus_if.readAddr2]);
      if (m_we) m_writes++;
      if (bus_if.memValid && !ready) m_stalls++;
      m_acc = bus_if.memValid && ready;
      e = '{a: bus_if.memAddr, d: bus_if.memData, p: bus_if.memPc};
      byp = 0;
      if (bus_if.aluValid) begin
        m_we = (bus_if.aluAddr != 0);
        m_addr = bus_if.aluAddr; m_data = bus_if.aluData; m_pc = bus_if.aluPc;
      end else if (q.size() > 0) begin
        retire(q.pop_front());
      end else if (m_acc) begin
        retire(e);
        byp = 1;
      end else begin
        m_we = 0;
      end
      if (m_acc && !byp) q.push_back(e);
      if (bus_if.loadIssue && bus_if.loadIssueAddr != 0) busy[bus_if.loadIssueAddr] = 1;
    end
    @(posedge clk);
    #1;
    chk("writeEnable", bus_if.writeEnable, m_we);
    if (m_we || in_rst) begin
      chk("writeAddr", bus_if.writeAddr, m_addr);
      chk("writeData", bus_if.writeData, m_data);
      chk("pc", bus_if.pc, m_pc);
    end
`ifdef WB_STATS_EN
    chk("statWrites", statWrites, m_writes);
    chk("statStalls", statStalls, m_stalls);
`endif
    @(negedge clk);
  endtask

  initial begin
    int k;
    idle();
    foreach (busy[i]) busy[i] = 0;
    m_we = 0; m_addr = 0; m_data = 0; m_pc = 0; m_acc = 0;
    m_writes = 0; m_stalls = 0;
    @(negedge clk);
    rstn = 0;
    step(); step();
    rstn = 1;

    // ALU write, one-cycle latency, then no strobe with held fields
    bus_if.aluValid = 1; bus_if.aluAddr = 5; bus_if.aluData = 32'h0000_1234; bus_if.aluPc = 32'h100;
    step();
    chk("t1_addr", bus_if.writeAddr, 5);
    chk("t1_data", bus_if.writeData, 32'h1234);
    idle();
    step();
    chk("t1_hold_addr", bus_if.writeAddr, 5);
    chk("t1_hold_pc", bus_if.pc, 32'h100);

    // Load-use: issue x7, observe busy, bypass the load, busy clears
    bus_if.loadIssue = 1; bus_if.loadIssueAddr = 7;
    step();
    idle(); bus_if.readAddr1 = 7;
    #1 chk("t2_busy_set", bus_if.busy1, 1);
    bus_if.memValid = 1; bus_if.memAddr = 7; bus_if.memData = 32'hDEAD_BEEF; bus_if.memPc = 32'h200;
    step();
    chk("t2_bypass_data", bus_if.writeData, 32'hDEAD_BEEF);
    idle(); bus_if.readAddr1 = 7;
    #1 chk("t2_busy_clear", bus_if.busy1, 0);
    step();

    // ALU busy for 6 cycles while loads x1..x5 are offered: FIFO fills, then drains in order
    k = 1;
    for (int c = 0; c < 6; c++) begin
      bus_if.aluValid = 1; bus_if.aluAddr = 5'(16 + c); bus_if.aluData = 32'hA000 + c; bus_if.aluPc = 32'h300 + 4 * c;
      bus_if.memValid = (k <= 5); bus_if.memAddr = 5'(k); bus_if.memData = 32'hB000 + k; bus_if.memPc = 32'h400 + 4 * k;
      step();
      if (m_acc) k++;
    end
    chk("t3_accepted_before_full", k, 5);
    bus_if.aluValid = 0;
    for (int c = 0; c < 12 && (k <= 5 || q.size() > 0); c++) begin
      bus_if.memValid = (k <= 5); bus_if.memAddr = 5'(k); bus_if.memData = 32'hB000 + k; bus_if.memPc = 32'h400 + 4 * k;
      step();
      if (m_acc) k++;
    end
    chk("t3_drained", q.size(), 0);
    idle();
    step();

    // x0 load is consumed silently; issue on x3 beats a retiring x3
    bus_if.memValid = 1; bus_if.memAddr = 0; bus_if.memData = 32'hFFFF_FFFF;
    bus_if.loadIssue = 1; bus_if.loadIssueAddr = 0;
    step();
    idle();
    bus_if.loadIssue = 1; bus_if.loadIssueAddr = 3;
    step();
    bus_if.memValid = 1; bus_if.memAddr = 3; bus_if.memData = 32'h3333; bus_if.memPc = 32'h500;
    step();
    idle(); bus_if.readAddr1 = 0; bus_if.readAddr2 = 3;
    #1 chk("t5_x0_busy", bus_if.busy1, 0);
    chk("t5_x3_busy_wins", bus_if.busy2, 1);
    step();

    // Reset with queued loads and busy bits outstanding
    bus_if.loadIssue = 1; bus_if.loadIssueAddr = 11;
    step();
    for (int c = 0; c < 3; c++) begin
      idle();
      bus_if.aluValid = 1; bus_if.aluAddr = 20; bus_if.aluData = c;
      bus_if.memValid = 1; bus_if.memAddr = 5'(8 + c); bus_if.memData = 32'hC000 + c;
      step();
    end
    chk("t6_queued", q.size(), 3);
    idle();
    rstn = 0;
    step();
    rstn = 1;
    bus_if.readAddr1 = 11; bus_if.readAddr2 = 3;
    #1 chk("t6_busy1_cleared", bus_if.busy1, 0);
    chk("t6_busy2_cleared", bus_if.busy2, 0);
    chk("t6_memReady", bus_if.memReady, 1);
    for (int c = 0; c < 3; c++) step();

    // Random traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      bus_if.aluValid      = ($urandom_range(0, 99) < 45);
      bus_if.aluAddr       = 5'($urandom_range(1, 31));
      bus_if.aluData       = $urandom;
      bus_if.aluPc         = $urandom;
      bus_if.memValid      = ($urandom_range(0, 99) < 60);
      bus_if.memAddr       = 5'($urandom_range(0, 31));
      bus_if.memData       = $urandom;
      bus_if.memPc         = $urandom;
      bus_if.loadIssue     = ($urandom_range(0, 99) < 30);
      bus_if.loadIssueAddr = 5'($urandom_range(0, 31));
      bus_if.readAddr1     = 5'($urandom_range(0, 31));
      bus_if.readAddr2     = 5'($urandom_range(0, 31));
      rstn                 = ($urandom_range(0, 99) != 0);
      step();
    end
    rstn = 1;
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
